// File: rtl/qspi_xip_reader_if.sv
// Fetch-side request/response bundle for qspi_xip_reader.
// master = fetch unit issuing reads, slave = the QSPI reader.
interface qspi_xip_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        err;

    modport master (
        output start, addr, len, rd_ready,
        input  busy, rd_data, rd_valid, err
    );

    modport slave (
        input  start, addr, len, rd_ready,
        output busy, rd_data, rd_valid, err
    );
endinterface

// File: rtl/qspi_xip_reader.sv
// Quad-I/O continuous-read master for the 256 KB program flash.
// Frame: 6 address nibbles, 2 mode nibbles, DUMMY_NIBBLES dummy nibbles,
// then data nibbles (high half first) assembled into a valid/ready byte stream.
// Each nibble spends one clk in L (spi_clk_out=0) and one in H (spi_clk_out=1).
// Optional feature macro: QSPI_BOUNDS_CHECK_EN rejects requests outside the
// 256 KB array with a one-cycle err pulse; without it err is constant 0.
module qspi_xip_reader #(
    parameter logic [7:0]  MODE_BITS      = 8'hA0,
    parameter int unsigned DUMMY_NIBBLES  = 4,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    qspi_xip_reader_if.slave        fetch,
    output logic                    spi_clk_out,
    output logic                    spi_cs_n,
    output logic [3:0]              spi_data_out,
    output logic [3:0]              spi_data_oe,
    input  logic [3:0]              spi_data_in
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_HOLD
    } state_t;

    localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_IDLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;      // 0 = L half, 1 = H half of a nibble
    logic [3:0]  cnt_q, cnt_d;          // nibble index in phase / hold countdown
    logic [23:0] addr_q, addr_d;        // shifts left so [23:20] is the live nibble
    logic [8:0]  bytes_q, bytes_d;      // bytes still to capture (up to 256)
    logic [3:0]  hi_q, hi_d;            // captured high nibble of current byte
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_q, err_d;
    logic        busy;
    logic        reject;

`ifdef QSPI_BOUNDS_CHECK_EN
    logic [24:0] end_addr;

    // Flag requests that reach outside the 256 KB array.
    always_comb begin
        end_addr = {1'b0, fetch.addr}
                 + ((fetch.len == 8'd0) ? 25'd256 : {17'd0, fetch.len});
        reject   = (fetch.addr[23:18] != 6'd0) || (end_addr > 25'h40000);
    end
`else
    assign reject = 1'b0;
`endif

    assign busy           = (state_q != S_IDLE) || rd_valid_q;
    assign fetch.busy     = busy;
    assign fetch.rd_data  = rd_data_q;
    assign fetch.rd_valid = rd_valid_q;
    assign fetch.err      = err_q;

    // State and datapath registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= 4'd0;
            addr_q     <= 24'd0;
            bytes_q    <= 9'd0;
            hi_q       <= 4'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            bytes_q    <= bytes_d;
            hi_q       <= hi_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Next-state: nibble sequencing, data capture and consumer backpressure.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        bytes_d    = bytes_q;
        hi_d       = hi_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !fetch.rd_ready;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch.start && !busy) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                        phase_d = 1'b0;
                        cnt_d   = 4'd0;
                        addr_d  = fetch.addr;
                        bytes_d = (fetch.len == 8'd0) ? 9'd256 : {1'b0, fetch.len};
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                if (!phase_q) begin
                    // L -> H: the flash nibble is sampled on this rising edge.
                    phase_d = 1'b1;
                    if (state_q == S_DATA) begin
                        if (!cnt_q[0]) begin
                            hi_d = spi_data_in;
                        end else begin
                            rd_data_d  = {hi_q, spi_data_in};
                            rd_valid_d = 1'b1;
                            bytes_d    = bytes_q - 9'd1;
                        end
                    end
                end else begin
                    // H -> L: advance to the next nibble; outputs change only here.
                    phase_d = 1'b0;
                    cnt_d   = cnt_q + 4'd1;
                    case (state_q)
                        S_ADDR: begin
                            addr_d = {addr_q[19:0], 4'h0};
                            if (cnt_q == 4'd5) begin
                                state_d = S_MODE;
                                cnt_d   = 4'd0;
                            end
                        end
                        S_MODE: begin
                            if (cnt_q == 4'd1) begin
                                state_d = S_DUMMY;
                                cnt_d   = 4'd0;
                            end
                        end
                        S_DUMMY: begin
                            if (cnt_q == DUMMY_LAST) begin
                                state_d = S_DATA;
                                cnt_d   = 4'd0;
                            end
                        end
                        default: begin
                            if (cnt_q[0]) begin
                                if (bytes_q == 9'd0) begin
                                    state_d = S_HOLD;
                                    cnt_d   = HOLD_LAST;
                                end else if (rd_valid_q && !fetch.rd_ready) begin
                                    // Previous byte not taken: park in H with clock high.
                                    phase_d = 1'b1;
                                    cnt_d   = cnt_q;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Pin outputs decoded from the registered state.
    always_comb begin
        spi_cs_n     = 1'b1;
        spi_clk_out  = 1'b0;
        spi_data_oe  = 4'h0;
        spi_data_out = 4'h0;
        case (state_q)
            S_ADDR: begin
                spi_cs_n     = 1'b0;
                spi_clk_out  = phase_q;
                spi_data_oe  = 4'hF;
                spi_data_out = addr_q[23:20];
            end
            S_MODE: begin
                spi_cs_n     = 1'b0;
                spi_clk_out  = phase_q;
                spi_data_oe  = 4'hF;
                spi_data_out = cnt_q[0] ? MODE_BITS[3:0] : MODE_BITS[7:4];
            end
            S_DUMMY, S_DATA: begin
                spi_cs_n    = 1'b0;
                spi_clk_out = phase_q;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_qspi_xip_reader.sv
// Self-checking bench for qspi_xip_reader: behavioural flash model,
// expected-byte queue filled at issue time, decoupled output monitor.
module tb_qspi_xip_reader;
    localparam int DUMMY      = 4;
    localparam int N0         = 8 + DUMMY;
    localparam int FIRST_EDGE = 2 * N0 + 3;
    localparam int WAIT_LIMIT = 4000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    qspi_xip_reader_if bus();
    logic       spi_clk_out;
    logic       spi_cs_n;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic [3:0] spi_data_in = 4'h0;

    qspi_xip_reader #(
        .MODE_BITS(8'hA0),
        .DUMMY_NIBBLES(DUMMY),
        .CS_IDLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .fetch(bus),
        .spi_clk_out(spi_clk_out),
        .spi_cs_n(spi_cs_n),
        .spi_data_out(spi_data_out),
        .spi_data_oe(spi_data_oe),
        .spi_data_in(spi_data_in)
    );

    logic [7:0]  mem [0:262143];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          rmode = 0;
    bit          stalled = 1'b0;
    int          stall_cnt = 0;
    logic [23:0] exp_addr = 24'd0;
    int          exp_rises = 0;
    bit          abort_flag = 1'b1;
    bit          first_pending = 1'b0;
    longint      e0_time = 0;
    longint      prev_t = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Flash model: counts rising SPI clocks per CS frame, decodes address and mode,
    // presents data nibbles for the next rising edge.
    initial begin
        int rise_cnt;
        int j;
        logic [23:0] fl_addr;
        logic [7:0]  b;
        rise_cnt = 0;
        fl_addr  = 24'd0;
        forever begin
            @(posedge spi_clk_out or posedge spi_cs_n);
            if (spi_cs_n) begin
                if (!abort_flag) chk("data_rises", rise_cnt, exp_rises);
                rise_cnt = 0;
            end else begin
                if (rise_cnt < 8) chk("oe_cmd", spi_data_oe, 4'hF);
                else              chk("oe_rx", spi_data_oe, 4'h0);
                if (rise_cnt < 6) fl_addr = {fl_addr[19:0], spi_data_out};
                else if (rise_cnt < 8) chk("mode_nib", spi_data_out, (rise_cnt == 6) ? 4'hA : 4'h0);
                rise_cnt++;
                if (rise_cnt == 6) chk("addr", fl_addr, exp_addr);
                if (rise_cnt >= N0) begin
                    j = rise_cnt - N0;
                    b = mem[18'(fl_addr + 24'(j / 2))];
                    spi_data_in = (j % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
        end
    end

    // Consumer ready: always, random, or a 10-cycle stall after the first byte.
    initial begin
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0: bus.rd_ready = 1'b1;
                1: bus.rd_ready = ($urandom % 3) != 0;
                default: begin
                    if (bus.rd_valid && !stalled) begin
                        stalled   = 1'b1;
                        stall_cnt = 10;
                    end
                    if (stall_cnt > 0) begin
                        bus.rd_ready = 1'b0;
                        stall_cnt--;
                    end else begin
                        bus.rd_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted byte.
    initial begin
        longint t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            t = $time;
            if (rstn) begin
                if (first_pending && bus.rd_valid) begin
                    first_pending = 1'b0;
                    chk("first_byte_edge", 32'((t - 5 - e0_time) / 10), FIRST_EDGE);
                end
                if (bus.rd_valid && !bus.rd_ready && !spi_cs_n)
                    chk("clk_held_in_stall", spi_clk_out, 1'b1);
                if (bus.rd_valid && bus.rd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", bus.rd_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", bus.rd_data, e);
                    end
                    if (rmode == 0 && prev_t >= 0) chk("byte_gap", 32'(t - prev_t), 40);
                    prev_t = t;
                end
            end
        end
    end

    task automatic wait_idle();
        int waited = 0;
        while (bus.busy && waited < WAIT_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        chk("idle_timeout", waited < WAIT_LIMIT, 1'b1);
    endtask

    // Issues one request; returns at the negedge after the accept edge E0.
    task automatic issue(input logic [23:0] a, input int n, input int mode);
        wait_idle();
        rmode         = mode;
        stalled       = 1'b0;
        stall_cnt     = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(mem[18'(a + 24'(i))]);
        exp_addr      = a;
        exp_rises     = N0 + 2 * n;
        abort_flag    = 1'b0;
        first_pending = 1'b1;
        prev_t        = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = a;
        bus.len   = n[7:0];
        @(posedge clk);
        e0_time = $time;
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", bus.busy, 1'b1);
        chk("err_on_accept", bus.err, 1'b0);
    endtask

    task automatic finish_req();
        wait_idle();
        chk("cs_idle_high", spi_cs_n, 1'b1);
        chk("all_bytes_seen", exp_q.size(), 0);
        chk("err_idle", bus.err, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
        mem[18'h00100] = 8'hA5;
        mem[18'h00200] = 8'h11;
        mem[18'h00201] = 8'h22;
        mem[18'h00202] = 8'h33;
        mem[18'h00203] = 8'h44;

        // Reset held with start asserted.
        bus.start = 1'b1;
        bus.addr  = 24'h000100;
        bus.len   = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_cs_n", spi_cs_n, 1'b1);
            chk("rst_spi_clk", spi_clk_out, 1'b0);
            chk("rst_oe", spi_data_oe, 4'h0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_rd_valid", bus.rd_valid, 1'b0);
        end
        chk("rst_rd_data", bus.rd_data, 8'h00);
        chk("rst_err", bus.err, 1'b0);
        bus.start = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte with exact framing.
        issue(24'h000100, 1, 0);
        repeat (27) @(negedge clk);
        chk("single_valid_e27", bus.rd_valid, 1'b1);
        chk("single_data_e27", bus.rd_data, 8'hA5);
        chk("single_cs_low_e27", spi_cs_n, 1'b0);
        @(negedge clk);
        chk("single_cs_high_e28", spi_cs_n, 1'b1);
        chk("single_clk_low_e28", spi_clk_out, 1'b0);
        chk("single_oe_e28", spi_data_oe, 4'h0);
        @(negedge clk);
        chk("single_busy_hold", bus.busy, 1'b1);
        @(negedge clk);
        chk("single_busy_clear", bus.busy, 1'b0);
        finish_req();

        // Four-byte burst; a start pulse mid-burst must be ignored.
        issue(24'h000200, 4, 0);
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = 24'h012345;
        bus.len   = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        finish_req();

        // Same burst with a 10-cycle consumer stall after the first byte.
        issue(24'h000200, 4, 2);
        finish_req();

        // Abort at E20, then a clean request.
        issue(24'h000100, 1, 0);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #1;
        abort_flag    = 1'b1;
        first_pending = 1'b0;
        exp_q.delete();
        rstn = 1'b0;
        #1;
        chk("abort_cs_high", spi_cs_n, 1'b1);
        chk("abort_clk_low", spi_clk_out, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_rd_valid", bus.rd_valid, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(24'h000100, 1, 0);
        finish_req();

        // Randomised requests, including the 256-byte length code.
        issue(24'($urandom_range(0, 262144 - 256)), 256, 1);
        finish_req();
        for (int k = 0; k < 7; k++) begin
            int n;
            n = $urandom_range(1, 40);
            issue(24'($urandom_range(0, 262144 - n)), n, $urandom_range(0, 1));
            finish_req();
        end

`ifdef QSPI_BOUNDS_CHECK_EN
        // Out-of-range requests are rejected with a single err cycle.
        for (int k = 0; k < 2; k++) begin
            wait_idle();
            @(negedge clk);
            bus.start = 1'b1;
            bus.addr  = (k == 0) ? 24'h03FFFE : 24'h040000;
            bus.len   = (k == 0) ? 8'd4 : 8'd1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            @(negedge clk);
            chk("reject_err_pulse", bus.err, 1'b1);
            chk("reject_busy", bus.busy, 1'b0);
            chk("reject_cs", spi_cs_n, 1'b1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("reject_err_one_cycle", bus.err, 1'b0);
                chk("reject_cs_stays_high", spi_cs_n, 1'b1);
            end
        end
        issue(24'h03FFFC, 4, 0);
        finish_req();
`else
        // Without bounds checking the request runs as given (flash wraps).
        issue(24'h03FFFE, 4, 0);
        finish_req();
`endif

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
